// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DREQ  = 3'd1,
    DWAIT = 3'd2,
    IREQ  = 3'd3,
    IWAIT = 3'd4
  } state_t;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

endpackage

// File: rtl/mem_arbiter_starve_cnt.sv
// Saturating count of consecutive instruction losses; sat forces the next grant to instruction.
module starve_cnt #(
  parameter int STARVE = 4,
  parameter int W      = $clog2(STARVE + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [W-1:0] MAX = W'(STARVE);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst)                    cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (inc && cnt != MAX)  cnt <= cnt + W'(1);
  end

  assign sat = (cnt == MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data side wins by default, instruction side forced after STARVE losses.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW,
  parameter int STARVE = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_ireq,
  input  logic [AW-1:0] i_iaddr,
  output logic [DW-1:0] o_iinst,
  output logic          o_ivalid,
  input  logic          i_dren,
  input  logic          i_dwen,
  input  logic [AW-1:0] i_daddr,
  input  logic [DW-1:0] i_dwdata,
  output logic [DW-1:0] o_drdata,
  output logic          o_dvalid,
  output logic          o_stall,
  output logic          o_mreq,
  output logic          o_mwe,
  output logic [AW-1:0] o_maddr,
  output logic [DW-1:0] o_mwdata,
  input  logic          i_mready,
  input  logic          i_mrvalid,
  input  logic [DW-1:0] i_mrdata
);

  state_t state;
  logic   wr_q;
  logic   data_req, grant_d, grant_i, starve_sat;

  assign data_req = i_dren | i_dwen;
  assign grant_d  = (state == IDLE) && data_req && !(i_ireq && starve_sat);
  assign grant_i  = (state == IDLE) && i_ireq && !grant_d;
  // A completion pulse releases the core even if another request is still up.
  assign o_stall  = (i_ireq | data_req) && !(o_ivalid | o_dvalid);

  starve_cnt #(.STARVE(STARVE)) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (grant_d & i_ireq),
    .clr (grant_i),
    .sat (starve_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      wr_q     <= 1'b0;
      o_mreq   <= 1'b0;
      o_mwe    <= 1'b0;
      o_maddr  <= '0;
      o_mwdata <= '0;
      o_ivalid <= 1'b0;
      o_dvalid <= 1'b0;
      o_iinst  <= '0;
      o_drdata <= '0;
    end else begin
      o_ivalid <= 1'b0;
      o_dvalid <= 1'b0;
      unique case (state)
        IDLE: begin
          // Store wins when both load and store are raised.
          if (grant_d) begin
            state    <= DREQ;
            o_mreq   <= 1'b1;
            o_mwe    <= i_dwen;
            wr_q     <= i_dwen;
            o_maddr  <= i_daddr;
            o_mwdata <= i_dwdata;
          end else if (grant_i) begin
            state    <= IREQ;
            o_mreq   <= 1'b1;
            o_mwe    <= 1'b0;
            wr_q     <= 1'b0;
            o_maddr  <= i_iaddr;
          end
        end
        DREQ: if (i_mready) begin
          o_mreq <= 1'b0;
          o_mwe  <= 1'b0;
          if (wr_q) begin
            o_dvalid <= 1'b1;
            state    <= IDLE;
          end else begin
            state    <= DWAIT;
          end
        end
        IREQ: if (i_mready) begin
          o_mreq <= 1'b0;
          state  <= IWAIT;
        end
        DWAIT: if (i_mrvalid) begin
          o_drdata <= i_mrdata;
          o_dvalid <= 1'b1;
          state    <= IDLE;
        end
        IWAIT: if (i_mrvalid) begin
          o_iinst  <= i_mrdata;
          o_ivalid <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
